// File: rtl/amber_ras.sv
// Return-address stack for the amber front end: predicts RET targets from
// recorded call return PCs, with wrap on overflow and checkpoint/restore for flushes.
module amber_ras #(
    parameter  int ADDR_W = 48,
    parameter  int DEPTH  = 8,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_push,
    input  logic [ADDR_W-1:0] iw_push_addr,
    input  logic              iw_pop,
    input  logic              iw_ckpt,
    input  logic              iw_restore,
    output logic [ADDR_W-1:0] ow_top,
    output logic              ow_valid,
    output logic [PTR_W:0]    ow_count,
    output logic              ow_overflow,
    output logic              ow_underflow
);

    localparam logic [PTR_W:0]   C_FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_tos;
    logic [PTR_W:0]    r_count;
    logic [PTR_W-1:0]  r_snap_tos;
    logic [PTR_W:0]    r_snap_count;
    logic              r_overflow;
    logic              r_underflow;

    logic [PTR_W-1:0]  w_tos_nxt;
    logic [PTR_W:0]    w_count_nxt;
    logic              w_wr_en;
    logic [PTR_W-1:0]  w_wr_idx;
    logic              w_ovf_nxt;
    logic              w_unf_nxt;
    logic              w_empty;
    logic              w_full;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_FULL);

    always_comb begin
        w_tos_nxt   = r_tos;
        w_count_nxt = r_count;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_tos;
        w_ovf_nxt   = 1'b0;
        w_unf_nxt   = 1'b0;
        if (iw_restore) begin
            w_tos_nxt   = r_snap_tos;
            w_count_nxt = r_snap_count;
        end else if (iw_push && iw_pop && !w_empty) begin
            // RET followed by tail call: replace the top in place
            w_wr_en = 1'b1;
        end else if (iw_push) begin
            w_tos_nxt = r_tos + C_PTR_ONE;
            w_wr_en   = 1'b1;
            w_wr_idx  = r_tos + C_PTR_ONE;
            if (w_full) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_count_nxt = r_count + C_CNT_ONE;
            end
        end else if (iw_pop) begin
            if (w_empty) begin
                w_unf_nxt = 1'b1;
            end else begin
                w_tos_nxt   = r_tos - C_PTR_ONE;
                w_count_nxt = r_count - C_CNT_ONE;
            end
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_tos        <= '0;
            r_count      <= '0;
            r_snap_tos   <= '0;
            r_snap_count <= '0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_tos       <= w_tos_nxt;
            r_count     <= w_count_nxt;
            r_overflow  <= w_ovf_nxt;
            r_underflow <= w_unf_nxt;
            // snapshot captures the state as it stands after this edge's update
            if (iw_ckpt) begin
                r_snap_tos   <= w_tos_nxt;
                r_snap_count <= w_count_nxt;
            end
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_wr_idx] <= iw_push_addr;
        end
    end

    assign ow_top       = r_mem[r_tos];
    assign ow_valid     = !w_empty;
    assign ow_count     = r_count;
    assign ow_overflow  = r_overflow;
    assign ow_underflow = r_underflow;

endmodule

// File: tb/tb_amber_ras.sv
// Bench for amber_ras: vector table through a scoreboard queue on a DEPTH=4
// instance, plus async-reset and DEPTH=16 overflow sequences.
module tb_amber_ras;

    logic        clk;
    logic        rst;
    logic        a_push, a_pop, a_ckpt, a_restore;
    logic [47:0] a_addr;
    logic [47:0] a_top;
    logic        a_valid, a_ovf, a_unf;
    logic [2:0]  a_count;

    logic        b_push, b_pop, b_ckpt, b_restore;
    logic [23:0] b_addr;
    logic [23:0] b_top;
    logic        b_valid, b_ovf, b_unf;
    logic [4:0]  b_count;

    int checks = 0;
    int errors = 0;

    amber_ras #(.ADDR_W(48), .DEPTH(4)) u_dut_a (
        .iw_clk(clk), .iw_rst(rst), .iw_push(a_push), .iw_push_addr(a_addr),
        .iw_pop(a_pop), .iw_ckpt(a_ckpt), .iw_restore(a_restore),
        .ow_top(a_top), .ow_valid(a_valid), .ow_count(a_count),
        .ow_overflow(a_ovf), .ow_underflow(a_unf)
    );

    amber_ras #(.ADDR_W(24), .DEPTH(16)) u_dut_b (
        .iw_clk(clk), .iw_rst(rst), .iw_push(b_push), .iw_push_addr(b_addr),
        .iw_pop(b_pop), .iw_ckpt(b_ckpt), .iw_restore(b_restore),
        .ow_top(b_top), .ow_valid(b_valid), .ow_count(b_count),
        .ow_overflow(b_ovf), .ow_underflow(b_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic        pop;
        logic        ckpt;
        logic        restore;
        logic [47:0] addr;
        logic [47:0] top;
        logic        chk_top;
        logic [2:0]  count;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(input logic push, input logic pop, input logic ckpt,
                                input logic restore, input logic [47:0] addr,
                                input logic [47:0] top, input logic chk_top,
                                input logic [2:0] count, input logic ovf, input logic unf);
        vec_t v;
        v.push = push; v.pop = pop; v.ckpt = ckpt; v.restore = restore;
        v.addr = addr; v.top = top; v.chk_top = chk_top; v.count = count;
        v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d] got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        a_push = v.push; a_pop = v.pop; a_ckpt = v.ckpt; a_restore = v.restore;
        a_addr = v.addr;
        sb.push_back(v);
        @(posedge clk);
        #1;
        a_push = 1'b0; a_pop = 1'b0; a_ckpt = 1'b0; a_restore = 1'b0;
        e = sb.pop_front();
        chk("count", idx, 64'(a_count), 64'(e.count));
        chk("valid", idx, 64'(a_valid), 64'(e.count != 0));
        chk("overflow", idx, 64'(a_ovf), 64'(e.ovf));
        chk("underflow", idx, 64'(a_unf), 64'(e.unf));
        if (e.chk_top) chk("top", idx, 64'(a_top), 64'(e.top));
    endtask

    initial begin
        int ovf_seen;
        a_push = 0; a_pop = 0; a_ckpt = 0; a_restore = 0; a_addr = '0;
        b_push = 0; b_pop = 0; b_ckpt = 0; b_restore = 0; b_addr = '0;
        rst = 1'b1;

        //          push pop ckpt rst addr   top    ct cnt ovf unf
        // simple push/pop
        tbl.push_back(mk(1, 0, 0, 0, 48'h0C, 48'h0C, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 48'h00, 48'h00, 0, 0, 0, 0));
        // nested calls, five iterations
        for (int it = 0; it < 5; it++) begin
            tbl.push_back(mk(1, 0, 0, 0, 48'h0C, 48'h0C, 1, 1, 0, 0));
            tbl.push_back(mk(1, 0, 0, 0, 48'h15, 48'h15, 1, 2, 0, 0));
            tbl.push_back(mk(0, 1, 0, 0, 48'h00, 48'h0C, 1, 1, 0, 0));
            tbl.push_back(mk(0, 1, 0, 0, 48'h00, 48'h00, 0, 0, 0, 0));
        end
        // overflow wrap
        tbl.push_back(mk(1, 0, 0, 0, 48'h1, 48'h1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 48'h2, 48'h2, 1, 2, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 48'h3, 48'h3, 1, 3, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 48'h4, 48'h4, 1, 4, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 48'h5, 48'h5, 1, 4, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 48'h0, 48'h4, 1, 3, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 48'h0, 48'h3, 1, 2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 48'h0, 48'h2, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 48'h0, 48'h0, 0, 0, 0, 0));
        // underflow, then push+pop replace
        tbl.push_back(mk(0, 1, 0, 0, 48'h0, 48'h0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 48'h0, 48'h0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 48'h10, 48'h10, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 48'h20, 48'h20, 1, 2, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 48'h30, 48'h30, 1, 2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 48'h0, 48'h10, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 48'h0, 48'h0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 48'h44, 48'h44, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 48'h0, 48'h0, 0, 0, 0, 0));
        // checkpoint / restore
        tbl.push_back(mk(1, 0, 0, 0, 48'hA, 48'hA, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 48'h0, 48'hA, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 48'hB, 48'hB, 1, 2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 48'h0, 48'hA, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 48'h0, 48'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 48'h0, 48'hA, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 48'h77, 48'hA, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 48'h0, 48'hA, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 48'h5B, 48'h5B, 1, 2, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 48'h6C, 48'h6C, 1, 3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 48'h0, 48'h5B, 1, 2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 48'h0, 48'hA, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 48'h0, 48'h0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 0, 64'(a_count), 64'd0);
        chk("rst_valid", 0, 64'(a_valid), 64'd0);
        chk("rst_top", 0, 64'(a_top), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // async reset between edges with count=3
        apply(mk(1, 0, 0, 0, 48'h111, 48'h111, 1, 1, 0, 0), 100);
        apply(mk(1, 0, 1, 0, 48'h222, 48'h222, 1, 2, 0, 0), 101);
        apply(mk(1, 0, 0, 0, 48'h333, 48'h333, 1, 3, 0, 0), 102);
        #2 rst = 1'b1;
        #1;
        chk("async_count", 103, 64'(a_count), 64'd0);
        chk("async_valid", 103, 64'(a_valid), 64'd0);
        chk("async_top", 103, 64'(a_top), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        apply(mk(0, 0, 0, 1, 48'h0, 48'h0, 1, 0, 0, 0), 104);
        apply(mk(1, 0, 0, 0, 48'h99, 48'h99, 1, 1, 0, 0), 105);

        // DEPTH=16 overflow rerun
        ovf_seen = 0;
        for (int i = 1; i <= 17; i++) begin
            b_push = 1'b1;
            b_addr = 24'(i);
            @(posedge clk);
            #1;
            if (b_ovf) ovf_seen++;
        end
        b_push = 1'b0;
        chk("b_ovf_pulses", 200, 64'(ovf_seen), 64'd1);
        chk("b_count", 200, 64'(b_count), 64'd16);
        chk("b_top", 200, 64'(b_top), 64'd17);
        b_pop = 1'b1;
        @(posedge clk);
        #1;
        b_pop = 1'b0;
        chk("b_ovf_clear", 201, 64'(b_ovf), 64'd0);
        chk("b_pop_top", 201, 64'(b_top), 64'd16);
        chk("b_pop_count", 201, 64'(b_count), 64'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
